// File: rtl/dcache_direct.sv
`default_nettype none
// ============================================================================
// Module   : dcache_direct
// Purpose  : Direct-mapped, write-through, no-write-allocate data cache for
//            16-bit words. It sits between the MEM pipeline stage and the SRAM
//            controller. Each line holds one word.
// Ports    : clk, rst (async, active-high)
//            Pipeline side : req, wr, addr[15:0], wdata[15:0] -> rdata, busy
//            Memory side   : mem_req, mem_we, mem_addr[17:0], mem_wdata[15:0]
//                            <- mem_rdata[15:0], mem_ready
//            Statistics    : hit_count, miss_count
// Options  : DCACHE_STATS_EN - when defined, hit_count and miss_count are
//            saturating counters. When undefined, both outputs are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module dcache_direct #(
    parameter int INDEX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [17:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    localparam int TAG_BITS = 16 - INDEX_BITS;
    localparam int c_LINES  = 1 << INDEX_BITS;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_RD_MISS = 2'd1;
    localparam logic [1:0] c_WR_THRU = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;

    logic [c_LINES-1:0]  r_valid;
    logic [TAG_BITS-1:0] r_tag  [c_LINES];
    logic [15:0]         r_data [c_LINES];

    logic [15:0]         r_addr;
    logic [15:0]         r_wdata;
    logic [15:0]         r_result;

    // Lookup for the live pipeline address (used in IDLE).
    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0]   w_tag;
    logic                  w_hit;
    assign w_idx = addr[INDEX_BITS-1:0];
    assign w_tag = addr[15:INDEX_BITS];
    assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

    // Lookup for the latched address (used while a memory access is pending).
    logic [INDEX_BITS-1:0] w_lat_idx;
    logic [TAG_BITS-1:0]   w_lat_tag;
    logic                  w_lat_hit;
    assign w_lat_idx = r_addr[INDEX_BITS-1:0];
    assign w_lat_tag = r_addr[15:INDEX_BITS];
    assign w_lat_hit = r_valid[w_lat_idx] && (r_tag[w_lat_idx] == w_lat_tag);

    logic w_start;      // IDLE request that needs the memory
    logic w_load_hit;   // IDLE load served from the cache
    logic w_fill;       // read miss completing this edge
    logic w_wr_done;    // write-through completing this edge
    assign w_load_hit = (r_state == c_IDLE) && req && !wr && w_hit;
    assign w_start    = (r_state == c_IDLE) && req && (wr || !w_hit);
    assign w_fill     = (r_state == c_RD_MISS) && mem_ready;
    assign w_wr_done  = (r_state == c_WR_THRU) && mem_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    w_next_state = wr ? c_WR_THRU : c_RD_MISS;
                end
            end
            c_RD_MISS: if (mem_ready) w_next_state = c_DONE;
            c_WR_THRU: if (mem_ready) w_next_state = c_DONE;
            // DONE consumes the held request, so req is not looked at here.
            default:   w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        busy      = 1'b0;
        rdata     = 16'd0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 18'd0;
        mem_wdata = 16'd0;
        case (r_state)
            c_IDLE: begin
                if (req) begin
                    if (!wr && w_hit) begin
                        rdata = r_data[w_idx];
                    end else begin
                        busy = 1'b1;
                    end
                end
            end
            c_RD_MISS: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {2'b00, r_addr};
            end
            c_WR_THRU: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = {2'b00, r_addr};
                mem_wdata = r_wdata;
            end
            default: begin
                rdata = r_result;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch and result register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= 16'd0;
            r_wdata  <= 16'd0;
            r_result <= 16'd0;
        end else begin
            if (w_start) begin
                r_addr <= addr;
                if (wr) begin
                    r_wdata <= wdata;
                end
            end
            if (w_fill) begin
                r_result <= mem_rdata;
            end else if (w_wr_done) begin
                r_result <= r_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Line storage. Only the valid bits need a reset; tag and data are
    // meaningless while the line is invalid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_fill) begin
            r_valid[w_lat_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_fill) begin
                r_tag[w_lat_idx]  <= w_lat_tag;
                r_data[w_lat_idx] <= mem_rdata;
            end else if (w_wr_done && w_lat_hit) begin
                // Write-through updates a resident line; misses do not allocate.
                r_data[w_lat_idx] <= r_wdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
`ifdef DCACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_count  <= 16'd0;
            r_miss_count <= 16'd0;
        end else begin
            if (w_load_hit && (r_hit_count != 16'hFFFF)) begin
                r_hit_count <= r_hit_count + 16'd1;
            end
            if (w_start && !wr && (r_miss_count != 16'hFFFF)) begin
                r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`else
    logic w_unused_stats;
    assign w_unused_stats = w_load_hit;
    assign hit_count  = 16'd0;
    assign miss_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_direct.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_direct
// Purpose  : Self-checking bench for dcache_direct. A driver issues directed
//            and random load/store requests, a reference model predicts each
//            response into a scoreboard queue, a monitor pops and compares on
//            every completed request, and a memory responder plays the SRAM
//            controller with per-request delays.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dcache_direct;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [17:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] hit_count;
    logic [15:0] miss_count;

    dcache_direct #(.INDEX_BITS(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .wr         (wr),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .busy       (busy),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard entry: expected rdata at completion and number of busy cycles.
    typedef struct {
        logic [15:0] rdata;
        int          busy_cyc;
    } exp_t;
    exp_t sb_q[$];

    // Reference model: the cache contents as seen from the outside, plus the
    // memory image the pipeline believes in. phys_mem is what the responder
    // actually holds, written only by the DUT's memory writes.
    bit          m_valid [64];
    logic [9:0]  m_tag   [64];
    logic [15:0] m_data  [64];
    logic [15:0] ref_mem  [65536];
    logic [15:0] phys_mem [65536];
    int          m_hits;
    int          m_misses;

    logic [15:0] cur_addr;
    logic        cur_wr;
    logic [15:0] cur_wdata;
    int          next_delay;
    bit          hold_mem;

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
    endtask

    // Issue one request and wait for the pipeline to be released.
    // Called and returns at posedge+1.
    task automatic do_req(input bit w, input logic [15:0] a, input logic [15:0] d, input int dly);
        exp_t e;
        int   idx;
        bit   hit;
        int   n;
        idx = int'(a[5:0]);
        hit = m_valid[idx] && (m_tag[idx] == a[15:6]);
        if (w) begin
            ref_mem[a] = d;
            if (hit) m_data[idx] = d;
            e.rdata    = d;
            e.busy_cyc = dly + 2;
        end else if (hit) begin
            e.rdata    = m_data[idx];
            e.busy_cyc = 0;
            m_hits++;
        end else begin
            m_valid[idx] = 1'b1;
            m_tag[idx]   = a[15:6];
            m_data[idx]  = ref_mem[a];
            e.rdata      = ref_mem[a];
            e.busy_cyc   = dly + 2;
            m_misses++;
        end
        sb_q.push_back(e);
        cur_addr   = a;
        cur_wr     = w;
        cur_wdata  = d;
        next_delay = dly;
        req   = 1'b1;
        wr    = w;
        addr  = a;
        wdata = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        if (busy) chk("req_timeout", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    // Monitor: a completion is any cycle where the request is present and
    // the pipeline is not stalled.
    initial begin
        int   bc;
        exp_t e;
        bc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bc = 0;
            end else if (req && busy) begin
                bc++;
            end else if (req && !busy) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_completion", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("rdata", 32'(rdata), 32'(e.rdata));
                    chk("busy_cycles", 32'(bc), 32'(e.busy_cyc));
                    chk("mem_req_at_completion", 32'(mem_req), 32'd0);
                end
                bc = 0;
            end
        end
    end

    // Memory responder: checks the request on every waiting cycle and pulses
    // mem_ready after next_delay extra cycles.
    initial begin
        int wl;
        wl        = -1;
        mem_ready = 1'b0;
        mem_rdata = 16'd0;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                mem_ready = 1'b0;
                mem_rdata = 16'($urandom);
                wl        = -1;
            end else if (rst || !mem_req) begin
                wl = -1;
            end else begin
                chk("mem_addr", 32'(mem_addr), 32'({2'b00, cur_addr}));
                chk("mem_we", 32'(mem_we), 32'(cur_wr));
                if (cur_wr) chk("mem_wdata", 32'(mem_wdata), 32'(cur_wdata));
                if (!hold_mem) begin
                    if (wl < 0) wl = next_delay;
                    if (wl == 0) begin
                        if (mem_we) phys_mem[mem_addr[15:0]] = mem_wdata;
                        mem_rdata = phys_mem[mem_addr[15:0]];
                        mem_ready = 1'b1;
                    end else begin
                        wl--;
                    end
                end
            end
        end
    end

    task automatic check_stats(input string tag);
`ifdef DCACHE_STATS_EN
        chk({tag, "_hit_count"}, 32'(hit_count), 32'(m_hits));
        chk({tag, "_miss_count"}, 32'(miss_count), 32'(m_misses));
`else
        chk({tag, "_hit_count"}, 32'(hit_count), 32'd0);
        chk({tag, "_miss_count"}, 32'(miss_count), 32'd0);
`endif
    endtask

    initial begin
        logic [15:0] v;
        logic [15:0] a;
        int          n;
        rst      = 1'b1;
        req      = 1'b0;
        wr       = 1'b0;
        addr     = 16'd0;
        wdata    = 16'd0;
        hold_mem = 1'b0;
        cur_addr   = 16'd0;
        cur_wr     = 1'b0;
        cur_wdata  = 16'd0;
        next_delay = 0;
        for (int i = 0; i < 65536; i++) begin
            v           = 16'($urandom);
            ref_mem[i]  = v;
            phys_mem[i] = v;
        end
        ref_mem[5]  = 16'hBEEF;
        phys_mem[5] = 16'hBEEF;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_mem_we", 32'(mem_we), 32'd0);
        chk("reset_rdata", 32'(rdata), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
        check_stats("reset");
        rst = 1'b0;

        // Directed sequence
        do_req(1'b0, 16'h0005, 16'h0000, 2);   // miss, BEEF, busy 4 cycles
        do_req(1'b0, 16'h0005, 16'h0000, 0);   // hit
        check_stats("after_first_hit");
        do_req(1'b1, 16'h0005, 16'h1234, 1);   // write-through, line updated
        do_req(1'b0, 16'h0005, 16'h0000, 0);   // hit 1234
        do_req(1'b1, 16'h0045, 16'hABCD, 0);   // same index, other tag: no allocate
        do_req(1'b0, 16'h0005, 16'h0000, 0);   // still hits 1234
        do_req(1'b0, 16'h0045, 16'h0000, 1);   // miss, replaces line, ABCD
        do_req(1'b0, 16'h0005, 16'h0000, 3);   // miss again, 1234
        do_req(1'b0, 16'hFFFF, 16'h0000, 0);   // last line, miss
        do_req(1'b0, 16'hFFFF, 16'h0000, 0);   // hit
        check_stats("directed");

        // Reset during RD_MISS before mem_ready
        hold_mem  = 1'b1;
        cur_addr  = 16'h0123;
        cur_wr    = 1'b0;
        req       = 1'b1;
        wr        = 1'b0;
        addr      = 16'h0123;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!mem_req && n < 10);
        chk("rd_miss_mem_req", 32'(mem_req), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        req = 1'b0;
        #1;
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        sb_q.delete();
        model_reset();
        hold_mem = 1'b0;
        @(posedge clk);
        #1;
        check_stats("abort");
        rst = 1'b0;
        do_req(1'b0, 16'h0123, 16'h0000, 1);   // must miss after reset
        do_req(1'b0, 16'h0123, 16'h0000, 0);   // now hits

        // Randomized traffic over a small address footprint to force hits,
        // aliasing and replacements.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 19) == 0) a = 16'($urandom);
            else a = {8'd0, 2'($urandom_range(0, 3)), 6'($urandom_range(0, 7))};
            do_req(($urandom_range(0, 3) == 0), a, 16'($urandom), int'($urandom_range(0, 4)));
        end
        check_stats("final");
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
